// File: rtl/stn2tft_cmd_seq_pkg.sv
// Shared constants for the STN-to-TFT host command sequencer: opcodes, per-opcode
// parameter counts and base addresses, FSM state encoding and register address width.
package stn2tft_cmd_pkg;

  localparam int REG_AW = 5;

  localparam logic [7:0] OP_SYS_SET   = 8'h40;
  localparam logic [7:0] OP_SCROLL    = 8'h44;
  localparam logic [7:0] OP_HDOT_SCR  = 8'h5A;
  localparam logic [7:0] OP_OVLAY     = 8'h5B;
  localparam logic [7:0] OP_CGRAM_ADR = 8'h5C;
  localparam logic [7:0] OP_CSR_FORM  = 8'h5D;
  localparam logic [7:0] OP_DISP_OFF  = 8'h58;
  localparam logic [7:0] OP_DISP_ON   = 8'h59;
  localparam logic [7:0] OP_SLEEP_IN  = 8'h53;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PARAM = 2'd1;
  localparam state_t ST_DROP  = 2'd2;

  typedef struct packed {
    logic              known;
    logic [3:0]        cnt;
    logic [REG_AW-1:0] base;
  } cmd_info_t;

  function automatic cmd_info_t cmd_lookup(input logic [7:0] op);
    cmd_info_t info;
    info = '0;
    case (op)
      OP_SYS_SET:   info = '{known: 1'b1, cnt: 4'd8,  base: 5'h00};
      OP_SCROLL:    info = '{known: 1'b1, cnt: 4'd10, base: 5'h08};
      OP_HDOT_SCR:  info = '{known: 1'b1, cnt: 4'd1,  base: 5'h12};
      OP_OVLAY:     info = '{known: 1'b1, cnt: 4'd1,  base: 5'h13};
      OP_CGRAM_ADR: info = '{known: 1'b1, cnt: 4'd2,  base: 5'h14};
      OP_CSR_FORM:  info = '{known: 1'b1, cnt: 4'd2,  base: 5'h16};
      OP_DISP_OFF:  info = '{known: 1'b1, cnt: 4'd1,  base: 5'h18};
      OP_DISP_ON:   info = '{known: 1'b1, cnt: 4'd1,  base: 5'h18};
      OP_SLEEP_IN:  info = '{known: 1'b1, cnt: 4'd0,  base: 5'h00};
      default:      info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/stn2tft_cmd_seq_if.sv
// 8080-style host write bus (chip enable, command/parameter select, write strobe, data).
// The host side drives every signal; the sequencer only samples. No ready: the host owns timing.
interface stn2tft_cmd_seq_if;
  logic       ce_x;
  logic       a0;
  logic       wr_x;
  logic [7:0] dat;

  modport master (output ce_x, a0, wr_x, dat);
  modport slave  (input  ce_x, a0, wr_x, dat);
endinterface

// File: rtl/stn2tft_cmd_seq_host_wr_sync.sv
// Synchronizes the asynchronous host strobes into clk and emits a one-cycle write event
// on each wr_x rising edge seen while ce_x is low, with the matching a0 and data byte.
module host_wr_sync #(
  parameter int NSYNC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_x,
  input  logic       wr_x,
  input  logic       a0,
  input  logic [7:0] dat,
  output logic       wr_evt,
  output logic       evt_a0,
  output logic [7:0] evt_dat
);

  logic [NSYNC-1:0] r_ce_sync;
  logic [NSYNC-1:0] r_wr_sync;
  logic [NSYNC-1:0] r_a0_sync;
  logic             r_wr_prev;
  logic [7:0]       r_dat;
  logic             w_wr_rise;

  // Strobes reset to the idle-high level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce_sync <= '1;
      r_wr_sync <= '1;
      r_a0_sync <= '1;
      r_wr_prev <= 1'b1;
      r_dat     <= 8'h00;
    end else begin
      r_ce_sync <= {r_ce_sync[NSYNC-2:0], ce_x};
      r_wr_sync <= {r_wr_sync[NSYNC-2:0], wr_x};
      r_a0_sync <= {r_a0_sync[NSYNC-2:0], a0};
      r_wr_prev <= r_wr_sync[NSYNC-1];
      r_dat     <= dat;
    end
  end

  // Data is quiet from wr_x low onward, so a single sampling stage is already settled here.
  assign w_wr_rise = r_wr_sync[NSYNC-1] & ~r_wr_prev;
  assign wr_evt    = w_wr_rise & ~r_ce_sync[NSYNC-1];
  assign evt_a0    = r_a0_sync[NSYNC-1];
  assign evt_dat   = r_dat;

endmodule

// File: rtl/stn2tft_cmd_seq.sv
// Host command sequencer: decodes command/parameter bytes into register-file writes and
// tracks display-on/sleep. Optional sticky protocol error flag under `STN2TFT_CMD_ERR_EN.
module stn2tft_cmd_seq
  import stn2tft_cmd_pkg::*;
#(
  parameter int NSYNC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  stn2tft_cmd_seq_if.slave     host,
  output logic                 reg_we,
  output logic [REG_AW-1:0]    reg_addr,
  output logic [7:0]           reg_wdat,
  output logic [7:0]           cmd_code,
  output logic                 sys_set_done,
  output logic                 disp_on,
  output logic                 sleep,
  output logic                 cmd_err,
  output state_t               o_dbg_state
);

  logic              w_wr_evt;
  logic              w_evt_a0;
  logic [7:0]        w_evt_dat;
  cmd_info_t         w_info;
  logic [3:0]        w_next_idx;
  logic [REG_AW-1:0] w_addr;

  state_t            r_state;
  logic [3:0]        r_idx;
  logic [3:0]        r_cnt;
  logic [REG_AW-1:0] r_base;
  logic              r_reg_we;
  logic [REG_AW-1:0] r_reg_addr;
  logic [7:0]        r_reg_wdat;
  logic [7:0]        r_cmd_code;
  logic              r_sys_set_done;
  logic              r_disp_on;
  logic              r_sleep;

  host_wr_sync #(.NSYNC(NSYNC)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .ce_x    (host.ce_x),
    .wr_x    (host.wr_x),
    .a0      (host.a0),
    .dat     (host.dat),
    .wr_evt  (w_wr_evt),
    .evt_a0  (w_evt_a0),
    .evt_dat (w_evt_dat)
  );

  assign w_info     = cmd_lookup(w_evt_dat);
  assign w_next_idx = r_idx + 4'd1;
  assign w_addr     = r_base + {1'b0, r_idx};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_idx          <= 4'd0;
      r_cnt          <= 4'd0;
      r_base         <= '0;
      r_reg_we       <= 1'b0;
      r_reg_addr     <= '0;
      r_reg_wdat     <= 8'h00;
      r_cmd_code     <= 8'h00;
      r_sys_set_done <= 1'b0;
      r_disp_on      <= 1'b0;
      r_sleep        <= 1'b0;
    end else begin
      r_reg_we       <= 1'b0;
      r_sys_set_done <= 1'b0;
      if (w_wr_evt) begin
        if (w_evt_a0) begin
          // A command byte always restarts decoding, abandoning any partial sequence.
          r_cmd_code <= w_evt_dat;
          r_idx      <= 4'd0;
          r_cnt      <= w_info.cnt;
          r_base     <= w_info.base;
          r_sleep    <= (w_evt_dat == OP_SLEEP_IN);
          if (w_evt_dat == OP_DISP_ON)
            r_disp_on <= 1'b1;
          else if (w_evt_dat == OP_DISP_OFF)
            r_disp_on <= 1'b0;
          if (!w_info.known)
            r_state <= ST_DROP;
          else if (w_info.cnt != 4'd0)
            r_state <= ST_PARAM;
          else
            r_state <= ST_IDLE;
        end else if (r_state == ST_PARAM) begin
          r_reg_we       <= 1'b1;
          r_reg_addr     <= w_addr;
          r_reg_wdat     <= w_evt_dat;
          r_sys_set_done <= (w_addr == 5'h07);
          r_idx          <= w_next_idx;
          if (w_next_idx == r_cnt)
            r_state <= ST_IDLE;
        end
      end
    end
  end

`ifdef STN2TFT_CMD_ERR_EN
  logic r_cmd_err;

  always_ff @(posedge clk) begin
    if (rst)
      r_cmd_err <= 1'b0;
    else if (w_wr_evt && ((w_evt_a0 && !w_info.known) ||
                          (!w_evt_a0 && r_state != ST_PARAM)))
      r_cmd_err <= 1'b1;
  end

  assign cmd_err = r_cmd_err;
`else
  assign cmd_err = 1'b0;
`endif

  assign reg_we       = r_reg_we;
  assign reg_addr     = r_reg_addr;
  assign reg_wdat     = r_reg_wdat;
  assign cmd_code     = r_cmd_code;
  assign sys_set_done = r_sys_set_done;
  assign disp_on      = r_disp_on;
  assign sleep        = r_sleep;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_stn2tft_cmd_seq.sv
// Directed bench for stn2tft_cmd_seq: host write driver, expected-write scoreboard with
// cycle-exact latency, state/flag checks and a final report.
module tb_stn2tft_cmd_seq;
  import stn2tft_cmd_pkg::*;

  localparam int NSYNC = 2;
  localparam int W     = 46;
`ifdef STN2TFT_CMD_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_we;
  logic [4:0]  reg_addr;
  logic [7:0]  reg_wdat;
  logic [7:0]  cmd_code;
  logic        sys_set_done;
  logic        disp_on;
  logic        sleep;
  logic        cmd_err;
  state_t      o_dbg_state;

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_item;
  logic [7:0]   rnd;

  stn2tft_cmd_seq_if hb ();

  stn2tft_cmd_seq #(.NSYNC(NSYNC)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (hb),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdat     (reg_wdat),
    .cmd_code     (cmd_code),
    .sys_set_done (sys_set_done),
    .disp_on      (disp_on),
    .sleep        (sleep),
    .cmd_err      (cmd_err),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // scoreboard: every reg_we must match the head of the expected queue, including its cycle
  always @(negedge clk) begin
    if (!rst && reg_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {31'b0, reg_we}, 32'd0);
      end else begin
        mon_item = exp_q.pop_front();
        chk("we_cycle",   cyc,                   mon_item[45:14]);
        chk("we_addr",    {27'b0, reg_addr},     {27'b0, mon_item[13:9]});
        chk("we_data",    {24'b0, reg_wdat},     {24'b0, mon_item[8:1]});
        chk("we_sysdone", {31'b0, sys_set_done}, {31'b0, mon_item[0]});
      end
    end
  end

  // driver: one full host write cycle with generous strobe timing
  task automatic host_write(input logic cev, input logic a0v, input logic [7:0] d,
                            input logic exp_we, input logic [4:0] exp_addr, input logic exp_sd);
    @(posedge clk); #1;
    hb.ce_x = cev; hb.a0 = a0v; hb.dat = d; hb.wr_x = 1'b0;
    repeat (NSYNC + 1) @(posedge clk);
    #1;
    hb.wr_x = 1'b1;
    if (exp_we) exp_q.push_back({32'(cyc + NSYNC + 1), exp_addr, d, exp_sd});
    repeat (NSYNC + 2) @(posedge clk);
    #1;
    hb.ce_x = 1'b1;
    repeat (NSYNC + 2) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [7:0] op);
    host_write(1'b0, 1'b1, op, 1'b0, 5'h00, 1'b0);
  endtask

  task automatic par(input logic [7:0] d, input logic we, input logic [4:0] addr);
    host_write(1'b0, 1'b0, d, we, addr, (we && addr == 5'h07));
  endtask

  initial begin
    logic [7:0] sys_p[8];
    sys_p[0] = 8'h30; sys_p[1] = 8'h87; sys_p[2] = 8'h07; sys_p[3] = 8'h27;
    sys_p[4] = 8'h2F; sys_p[5] = 8'hC7; sys_p[6] = 8'h28; sys_p[7] = 8'h00;

    hb.ce_x = 1'b1; hb.wr_x = 1'b1; hb.a0 = 1'b0; hb.dat = 8'h00;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (NSYNC + 2) @(posedge clk);
    #1;

    // reset state
    chk("rst_we",      {31'b0, reg_we},       32'd0);
    chk("rst_cmd",     {24'b0, cmd_code},     32'd0);
    chk("rst_disp",    {31'b0, disp_on},      32'd0);
    chk("rst_sleep",   {31'b0, sleep},        32'd0);
    chk("rst_err",     {31'b0, cmd_err},      32'd0);
    chk("rst_sysdone", {31'b0, sys_set_done}, 32'd0);
    chk("rst_state",   {30'b0, o_dbg_state},  {30'b0, ST_IDLE});

    // SYSTEM SET, full parameter list
    cmd(OP_SYS_SET);
    chk("sys_state_param", {30'b0, o_dbg_state}, {30'b0, ST_PARAM});
    for (int i = 0; i < 8; i++) par(sys_p[i], 1'b1, 5'(i));
    chk("sys_state_idle", {30'b0, o_dbg_state}, {30'b0, ST_IDLE});
    chk("sys_cmd",        {24'b0, cmd_code},    32'h40);

    // aborted SYSTEM SET, then HDOT SCR
    cmd(OP_SYS_SET);
    for (int i = 0; i < 3; i++) par(8'(8'hA0 + i), 1'b1, 5'(i));
    cmd(OP_HDOT_SCR);
    par(8'h05, 1'b1, 5'h12);
    chk("hdot_cmd",   {24'b0, cmd_code},    32'h5A);
    chk("hdot_state", {30'b0, o_dbg_state}, {30'b0, ST_IDLE});

    // display on / sleep / display off
    cmd(OP_DISP_ON);
    par(8'h14, 1'b1, 5'h18);
    chk("dispon_disp", {31'b0, disp_on}, 32'd1);
    cmd(OP_SLEEP_IN);
    chk("sleep_set",   {31'b0, sleep},   32'd1);
    chk("sleep_disp",  {31'b0, disp_on}, 32'd1);
    chk("sleep_state", {30'b0, o_dbg_state}, {30'b0, ST_IDLE});
    cmd(OP_DISP_OFF);
    par(8'h00, 1'b1, 5'h18);
    chk("dispoff_disp",  {31'b0, disp_on}, 32'd0);
    chk("dispoff_sleep", {31'b0, sleep},   32'd0);
    chk("no_err_yet",    {31'b0, cmd_err}, 32'd0);

    // OVLAY with an overrun parameter
    cmd(OP_OVLAY);
    par(8'h01, 1'b1, 5'h13);
    par(8'h02, 1'b0, 5'h00);
    chk("overrun_err", {31'b0, cmd_err}, {31'b0, ERR_EN});

    // chip enable high: byte ignored entirely
    host_write(1'b1, 1'b1, 8'h77, 1'b0, 5'h00, 1'b0);
    chk("ce_high_cmd",   {24'b0, cmd_code},    32'h5B);
    chk("ce_high_state", {30'b0, o_dbg_state}, {30'b0, ST_IDLE});

    // unknown opcode and dropped parameter
    cmd(8'h77);
    chk("unk_state", {30'b0, o_dbg_state}, {30'b0, ST_DROP});
    chk("unk_cmd",   {24'b0, cmd_code},    32'h77);
    par(8'hAA, 1'b0, 5'h00);
    chk("unk_err",   {31'b0, cmd_err},     {31'b0, ERR_EN});

    // reset in the middle of SCROLL parameter 5
    cmd(OP_DISP_ON);
    par(8'h33, 1'b1, 5'h18);
    cmd(OP_SCROLL);
    for (int i = 0; i < 4; i++) begin
      rnd = 8'($urandom_range(0, 255));
      par(rnd, 1'b1, 5'(8 + i));
    end
    chk("pre_rst_disp", {31'b0, disp_on}, 32'd1);
    @(posedge clk); #1;
    hb.ce_x = 1'b0; hb.a0 = 1'b0; hb.dat = 8'h5E; hb.wr_x = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_we",    {31'b0, reg_we},       32'd0);
    chk("mid_rst_addr",  {27'b0, reg_addr},     32'd0);
    chk("mid_rst_wdat",  {24'b0, reg_wdat},     32'd0);
    chk("mid_rst_cmd",   {24'b0, cmd_code},     32'd0);
    chk("mid_rst_disp",  {31'b0, disp_on},      32'd0);
    chk("mid_rst_sleep", {31'b0, sleep},        32'd0);
    chk("mid_rst_err",   {31'b0, cmd_err},      32'd0);
    chk("mid_rst_sd",    {31'b0, sys_set_done}, 32'd0);
    chk("mid_rst_state", {30'b0, o_dbg_state},  {30'b0, ST_IDLE});
    repeat (NSYNC + 1) @(posedge clk);
    #1 hb.wr_x = 1'b1;
    repeat (NSYNC + 2) @(posedge clk);
    #1 hb.ce_x = 1'b1;
    repeat (NSYNC + 2) @(posedge clk);
    #1;
    chk("post_rst_state", {30'b0, o_dbg_state}, {30'b0, ST_IDLE});
    chk("post_rst_err",   {31'b0, cmd_err},     {31'b0, ERR_EN});

    // full SCROLL and the two-parameter commands with random data
    cmd(OP_SCROLL);
    for (int i = 0; i < 10; i++) begin
      rnd = 8'($urandom_range(0, 255));
      par(rnd, 1'b1, 5'(8 + i));
    end
    chk("scroll_state", {30'b0, o_dbg_state}, {30'b0, ST_IDLE});
    cmd(OP_CGRAM_ADR);
    for (int i = 0; i < 2; i++) par(8'($urandom_range(0, 255)), 1'b1, 5'(8'h14 + i));
    cmd(OP_CSR_FORM);
    for (int i = 0; i < 2; i++) par(8'($urandom_range(0, 255)), 1'b1, 5'(8'h16 + i));
    chk("csr_cmd",   {24'b0, cmd_code},    32'h5D);
    chk("csr_state", {30'b0, o_dbg_state}, {30'b0, ST_IDLE});

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stn2tft_cmd_seq.md
# stn2tft_cmd_seq

Host command sequencer for the STN-to-TFT converter. It samples the S1D13700-style 8080 write bus (`ce_x`, `a0`, `wr_x`, `dat`) and decodes each command byte and the parameter bytes that follow it. It turns these into addressed single-cycle writes into the converter's register file, and maintains the display-on and sleep state that gates the TFT timing generator. It sits between the pad-level host interface and the register/timing blocks of `stn2tft_top`.

## Interface
- `NSYNC`, 2: synchronizer depth on host strobes (≥2).
- `clk` in 1: system clock (MCLKI domain).
- `rst` in 1: synchronous, active-high reset.
- `ce_x` in 1: host chip enable, active low, asynchronous to `clk`.
- `a0` in 1: 1 = command byte, 0 = parameter byte.
- `wr_x` in 1: host write strobe, active low; a byte is taken on its rising edge.
- `dat` in 8: host data bus.
- `reg_we` out 1: one-cycle register write strobe.
- `reg_addr` out 5: register file address.
- `reg_wdat` out 8: register write data.
- `cmd_code` out 8: last accepted command opcode.
- `sys_set_done` out 1: one-cycle pulse when the 8th SYSTEM SET parameter is written.
- `disp_on` out 1: display enable state.
- `sleep` out 1: sleep state.
- `cmd_err` out 1: sticky protocol error flag (see Configuration).

## Operation
- Host write event: `wr_x` rising edge after synchronization, with the synchronized `ce_x` = 0 at that edge. `a0` and `dat` are captured on the same clock as the edge detect.
- Command table (opcode: parameter count, base address):
  - 0x40 SYSTEM SET: 8, 0x00.
  - 0x44 SCROLL: 10, 0x08.
  - 0x5A HDOT SCR: 1, 0x12.
  - 0x5B OVLAY: 1, 0x13.
  - 0x5C CGRAM ADR: 2, 0x14.
  - 0x5D CSR FORM: 2, 0x16.
  - 0x58 DISP OFF: 1, 0x18.
  - 0x59 DISP ON: 1, 0x18.
  - 0x53 SLEEP IN: 0.
- FSM states: IDLE, PARAM, DROP.
  - Command byte, any state: load `cmd_code`, clear the parameter index.
    - Known opcode with count > 0 → PARAM.
    - 0x53 → set `sleep`, go to IDLE.
    - Unknown opcode → DROP.
  - PARAM + parameter byte: `reg_we`=1, `reg_addr` = base + index, `reg_wdat` = byte, index += 1. When index reaches count → IDLE.
  - IDLE or DROP + parameter byte: ignored, no `reg_we`.
- Side effects:
  - Accepting 0x59 sets `disp_on`; accepting 0x58 clears it.
  - Any command byte other than 0x53 clears `sleep`.
  - `sys_set_done` fires together with the write to address 0x07.
- Address arithmetic: 5-bit unsigned. The index is 4 bits. Base + count never exceeds 0x19, so no wrap occurs.
- Abort: a new command byte mid-sequence abandons the old one. Registers already written keep their values.

## Timing
- Latency: `reg_we` asserts exactly NSYNC+1 clocks after the `wr_x` rising edge at the pin.
- Host data must be stable from `wr_x` low until NSYNC+2 clocks after `wr_x` rises. Minimum `wr_x` high and low time is NSYNC+1 clocks each.
- At most one `reg_we` per host write. `reg_addr` and `reg_wdat` hold their values until the next write.
- Reset values: all outputs 0, including `disp_on`, `sleep` and `cmd_err`; `cmd_code` = 0x00; FSM = IDLE; synchronizers = 1 (idle high).
- Reset mid-sequence returns to IDLE. The first byte after reset is treated as a new write only after a fresh `wr_x` rising edge; there is no spurious edge out of reset.
- `ce_x` high at the edge: the byte is ignored entirely, with no state change.

## Configuration
- `STN2TFT_CMD_ERR_EN` defined: `cmd_err` sets, and holds until reset, on either of:
  - an unknown opcode;
  - a parameter byte in IDLE or DROP (overrun).
- `STN2TFT_CMD_ERR_EN` undefined: `cmd_err` is tied 0 and the error logic is removed. Bytes are still dropped identically.

## Structure
- Package `stn2tft_cmd_pkg`:
  - opcode constants;
  - per-opcode parameter counts and base addresses;
  - FSM state typedef;
  - register address width.
- Sub-module `host_wr_sync`: NSYNC-stage synchronizer on `ce_x`/`wr_x`/`a0`, rising-edge detect, and `dat` capture. It outputs a one-cycle `wr_evt`, `evt_a0` and `evt_dat`.

## Test plan
- Cmd 0x40, then params 0x30,0x87,0x07,0x27,0x2F,0xC7,0x28,0x00 → 8 `reg_we` at addr 0x00–0x07 with matching data; `sys_set_done` coincident with addr 0x07; FSM back in IDLE.
- Cmd 0x40, 3 params, then cmd 0x5A, param 0x05 → writes to 0x00–0x02, then 0x12=0x05; `cmd_code`=0x5A.
- Cmd 0x59 with param 0x14 → 0x18=0x14 and `disp_on`=1. Then cmd 0x53 → `sleep`=1. Then cmd 0x58 with param 0x00 → `disp_on`=0, `sleep`=0.
- Cmd 0x5B, params 0x01,0x02 → one write (0x13=0x01). With the macro, `cmd_err`=1 after the 2nd param; without it, `cmd_err` stays 0.
- Cmd 0x77, then param 0xAA → no `reg_we`; `cmd_err`=1 when the macro is defined.
- `rst` asserted during SCROLL param 5 → all outputs 0, FSM IDLE; a following param byte produces no write.
